// File: rtl/tensor_matmul_operand_sequencer_if.sv
// Operand-side bus of the matmul operand sequencer.
// Carries the A/B SRAM read ports (1-cycle read latency) and the paired
// operand stream to the MAC unit.
//   master : the sequencer (drives read strobes/addresses and the stream)
//   slave  : SRAMs plus consumer (return read data, drive ready_in)
interface tensor_matmul_operand_sequencer_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  logic [DATA_W-1:0] a_rd_data;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [DATA_W-1:0] b_rd_data;
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              first_l;
  logic              last_l;

  modport master (
    output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    output valid_out, data_a, data_b, first_l, last_l,
    input  a_rd_data, b_rd_data, ready_in
  );

  modport slave (
    input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    input  valid_out, data_a, data_b, first_l, last_l,
    output a_rd_data, b_rd_data, ready_in
  );
endinterface

// File: rtl/tensor_matmul_operand_sequencer.sv
// Operand sequencer for C[row,k] = sum_l A[row,l]*B[l,k].
// Walks row (outer) / k (middle) / l (inner), reads A[row*L+l] and
// B[l*K+k] from 1-cycle-latency SRAMs and streams the operand pairs,
// tagged first_l/last_l, through a 2-entry FIFO with valid/ready.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start, cfg_rows/l/k    job launch and dimensions (sampled at accepted start)
//   busy, done             job in progress / one-cycle completion pulse
//   bus (master modport)   SRAM read ports and operand stream
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads under the FIFO credit limit
// DRAIN | all reads issued; waiting for FIFO and in-flight read to empty
// ZERO  | degenerate job (a dimension is 0): done for one cycle, no reads
module tensor_matmul_operand_sequencer #(
  parameter int ROW_W  = 16,
  parameter int L_W    = 12,
  parameter int K_W    = 12,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [L_W-1:0]   cfg_l,
  input  logic [K_W-1:0]   cfg_k,
  output logic             busy,
  output logic             done,
  tensor_matmul_operand_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ZERO} state_e;
  state_e state_q, state_d;

  logic [ROW_W-1:0]  rows_q, row_q;
  logic [L_W-1:0]    l_len_q, l_q;
  logic [K_W-1:0]    k_len_q, k_q;
  logic [ADDR_W-1:0] a_base_q, b_addr_q;
  logic              infl_q, infl_first_q, infl_last_q;
  logic [DATA_W-1:0] fa_q [2];
  logic [DATA_W-1:0] fb_q [2];
  logic [1:0]        ff_q, fl_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q;
  logic              done_q;

  logic accept, cfg_zero, pop, push, issue;
  logic l_end, k_end, row_end, last_read, valid;

  assign accept   = start && (state_q == S_IDLE);
  assign cfg_zero = (cfg_rows == '0) || (cfg_l == '0) || (cfg_k == '0);
  assign valid    = (cnt_q != 2'd0);
  assign pop      = valid && bus.ready_in;
  assign push     = infl_q;
  // Credit: entries held + read in flight, minus the pair leaving now,
  // must leave room for the read about to be issued.
  assign issue    = (state_q == S_RUN) &&
                    (({1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2);

  assign l_end     = (l_q == l_len_q - L_W'(1));
  assign k_end     = (k_q == k_len_q - K_W'(1));
  assign row_end   = (row_q == rows_q - ROW_W'(1));
  assign last_read = issue && l_end && k_end && row_end;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = cfg_zero ? S_ZERO : S_RUN;
      S_RUN:   if (last_read) state_d = S_DRAIN;
      S_DRAIN: if ((cnt_q == 2'd0) && !infl_q) state_d = S_IDLE;
      S_ZERO:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DRAIN) && (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q       <= '0;
      l_len_q      <= '0;
      k_len_q      <= '0;
      row_q        <= '0;
      l_q          <= '0;
      k_q          <= '0;
      a_base_q     <= '0;
      b_addr_q     <= '0;
      infl_q       <= 1'b0;
      infl_first_q <= 1'b0;
      infl_last_q  <= 1'b0;
      fa_q[0]      <= '0;
      fa_q[1]      <= '0;
      fb_q[0]      <= '0;
      fb_q[1]      <= '0;
      ff_q         <= '0;
      fl_q         <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        rows_q   <= cfg_rows;
        l_len_q  <= cfg_l;
        k_len_q  <= cfg_k;
        row_q    <= '0;
        l_q      <= '0;
        k_q      <= '0;
        a_base_q <= '0;
        b_addr_q <= '0;
      end else if (issue) begin
        if (l_end) begin
          l_q <= '0;
          if (k_end) begin
            k_q      <= '0;
            row_q    <= row_q + ROW_W'(1);
            a_base_q <= a_base_q + ADDR_W'(l_len_q);
            b_addr_q <= '0;
          end else begin
            k_q      <= k_q + K_W'(1);
            // B column restarts at row l=0 of the next column
            b_addr_q <= ADDR_W'(k_q) + ADDR_W'(1);
          end
        end else begin
          l_q      <= l_q + L_W'(1);
          b_addr_q <= b_addr_q + ADDR_W'(k_len_q);
        end
      end

      infl_q <= issue;
      if (issue) begin
        infl_first_q <= (l_q == '0);
        infl_last_q  <= l_end;
      end

      if (push) begin
        fa_q[wr_ptr_q] <= bus.a_rd_data;
        fb_q[wr_ptr_q] <= bus.b_rd_data;
        ff_q[wr_ptr_q] <= infl_first_q;
        fl_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q       <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = done_q || (state_q == S_ZERO);

  assign bus.a_rd_en   = issue;
  assign bus.b_rd_en   = issue;
  assign bus.a_rd_addr = issue ? (a_base_q + ADDR_W'(l_q)) : '0;
  assign bus.b_rd_addr = issue ? b_addr_q : '0;

  assign bus.valid_out = valid;
  assign bus.data_a    = valid ? fa_q[rd_ptr_q] : '0;
  assign bus.data_b    = valid ? fb_q[rd_ptr_q] : '0;
  assign bus.first_l   = valid && ff_q[rd_ptr_q];
  assign bus.last_l    = valid && fl_q[rd_ptr_q];

endmodule

// File: doc/tensor_matmul_operand_sequencer.md
Name: tensor_matmul_operand_sequencer

Overview:
- Initiator side of the 4D tensor matmul datapath: C[row,k] = sum_l A[row,l]*B[l,k], with row = flattened (b,i,j).
- Walks the row/k/l loop nest and issues read addresses to the A and B operand SRAMs (1-cycle read latency).
- Streams paired operands (data_a, data_b) with valid_out/ready_in to the downstream MAC/matmul unit.
- Flags first_l/last_l so the consumer can clear and close each accumulation.

Parameters:
- ROW_W, 16, width of cfg_rows (row count = b*i*j).
- L_W, 12, width of cfg_l (reduction length).
- K_W, 12, width of cfg_k (output columns).
- ADDR_W, 20, width of the A and B read addresses.
- DATA_W, 32, operand width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job launch; ignored while busy
- cfg_rows  in  ROW_W  row count, sampled at the accepted start
- cfg_l  in  L_W  reduction length, sampled at the accepted start
- cfg_k  in  K_W  column count, sampled at the accepted start
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at job end
- a_rd_en  out  1  A SRAM read strobe
- a_rd_addr  out  ADDR_W  A address = row*L + l
- a_rd_data  in  DATA_W  valid the cycle after a_rd_en
- b_rd_en  out  1  B SRAM read strobe; always equal to a_rd_en
- b_rd_addr  out  ADDR_W  B address = l*K + k
- b_rd_data  in  DATA_W  valid the cycle after b_rd_en
- valid_out  out  1  operand pair available
- ready_in  in  1  downstream accepts the pair
- data_a  out  DATA_W  A operand
- data_b  out  DATA_W  B operand
- first_l  out  1  pair has l==0
- last_l  out  1  pair has l==L-1

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters, credit and FIFO cleared. Reset mid-job aborts immediately, with no done pulse.
- States and transitions:
  - IDLE -> RUN on start with all cfg fields nonzero.
  - IDLE -> ZERO on start with any cfg field 0.
  - ZERO: done=1 for one cycle, no reads issued, then IDLE.
  - RUN: issues reads; -> DRAIN after the read for (row=R-1, k=K-1, l=L-1) is issued.
  - DRAIN: -> IDLE when the FIFO is empty and nothing is in flight; done pulses for one cycle in the IDLE entry cycle.
  - busy is high in RUN and DRAIN. The ZERO cycle raises done without busy.
- Loop order: row outer, k middle, l inner.
- Address generation uses no multipliers:
  - a_base advances by L per row.
  - a_rd_addr = a_base + l.
  - b_rd_addr advances by K per l; at l wrap it reloads to the next k.
  - Addresses wrap modulo 2^ADDR_W.
- Read data pipeline:
  - Read data lands in a 2-entry operand FIFO one cycle after the strobe, tagged with first_l/last_l.
  - The FIFO head drives data_a, data_b, first_l, last_l and valid_out.
- Credit rule: issue a read in RUN only when fifo_count + inflight - pop < 2, where pop = valid_out & ready_in in the same cycle. The FIFO therefore never overflows.
- Throughput: with ready_in held high, one pair per cycle is sustained.
- Latency: start sampled at edge E0; the first read strobe is high in cycle E0-E1; the data is captured at E2; valid_out is high after E2.
- Handshake:
  - Once valid_out is high, it and all payload outputs hold stable until ready_in.
  - ready_in may be low arbitrarily long; reads stall with no address skipped or duplicated.
- start while busy is ignored, and cfg is not resampled.
- Pair count per job: exactly R*K*L pairs leave the block. first_l and last_l are both high on every pair when L=1.

Test Plan:
- R=2,K=2,L=3, ready_in=1, A[x]=x, B[x]=100+x:
  - 12 pairs, l innermost.
  - First three pairs (data_a,data_b) = (0,100),(1,102),(2,104).
  - Then (0,101),(1,103),(2,105).
  - first_l on pairs 0,3,6,9; last_l on 2,5,8,11.
  - First valid_out 2 edges after start; no bubbles; done one cycle after the 12th handshake.
- Same job with ready_in toggling 1,0,0,1 pseudo-randomly:
  - Identical pair sequence.
  - Payload stable while valid_out&!ready_in.
  - Never more than 2 outstanding reads+entries.
- cfg_l=0 (R=4,K=4):
  - done pulses the cycle after start.
  - busy stays 0, no rd_en, no valid_out.
- start pulsed again mid-job with different cfg: ignored; original 12-pair sequence and a single done.
- rst_n asserted low after 5 handshakes:
  - All outputs 0 asynchronously.
  - No done pulse.
  - A new start then produces the full sequence from pair 0.
- R=1,K=1,L=1: one pair with first_l=last_l=1, a_rd_addr=0, b_rd_addr=0; done after the handshake.
